mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide unit for the single-cycle core. It sits directly downstream of the register file: it takes the two register read operands and the instruction's funct3, computes over multiple cycles, and returns a 32-bit result for the writeback path. While it computes, it stalls the core through `busy`.

## Interface
Parameters:
- `XLEN`, 32: operand and result width. Only 32 is supported.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `start`  in  1  launches an operation; sampled only in IDLE.
- `funct3`  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `opA`  in  32  rs1 value (regData1).
- `opB`  in  32  rs2 value (regData2).
- `busy`  out  1  high whenever the state is not IDLE; the core stalls its PC and regfile write while it is high.
- `done`  out  1  one-cycle pulse; `result` is valid in that cycle.
- `result`  out  32  registered result; held until the next accepted start.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE with `start`=1:
  - latch `opA`, `opB` and `funct3`;
  - record the operand signs per op (MULH/DIV/REM: both signed; MULHSU: opA signed only; others: unsigned);
  - store the absolute values.
  - If a special case applies, write `result` and go to DONE. Otherwise clear the iteration counter (6 bits) and the accumulator, then go to CALC.
- CALC, multiply: radix-2 shift-add into a 64-bit product, one multiplier bit per cycle, 32 iterations.
- CALC, divide: restoring division producing one quotient bit per cycle with a 33-bit partial remainder, 32 iterations.
- CALC exit: after iteration 31, apply sign correction and select the result, then go to DONE.
  - Product negated if the operand signs differ.
  - Quotient negated if the signs differ.
  - Remainder takes the dividend's sign.
  - Result is product[31:0] for MUL and product[63:32] for MULH/MULHSU/MULHU.
- DONE: `done`=1 for one cycle, then go to IDLE unconditionally.
- Special cases (no CALC):
  - divide by zero: DIV/DIVU result 0xFFFFFFFF; REM/REMU result opA.
  - signed overflow (DIV or REM with opA=0x80000000, opB=0xFFFFFFFF): DIV result 0x80000000, REM result 0.
- `start` while `busy`: ignored. No queuing and no effect on the operation in progress.
- Input changes after acceptance: ignored, because all operands are latched.
- All arithmetic is modulo 2^32 or 2^64. Negation is two's complement, so |0x80000000| = 0x80000000 as unsigned, which is correct.

## Timing
- Reset (`rst`=0, at any time, including mid-CALC): state IDLE, `busy`=0, `done`=0, `result`=0, counter and accumulators 0. Operation resumes on the first rising edge after `rst` returns high.
- Normal op, `start` high in cycle N:
  - `busy` high in cycles N+1 through N+33;
  - CALC covers cycles N+1 through N+32;
  - `done`=1 in cycle N+33;
  - IDLE in cycle N+34, where a new `start` can be accepted.
- Special case, `start` in cycle N: `busy` and `done` high in cycle N+1; IDLE in cycle N+2.
- `busy` is not asserted in cycle N itself. The core holds the instruction stable because it sees `start` combinationally and gates its own stall with it.
- `result` changes only at the CALC→DONE edge or the special-case edge, and is otherwise stable.

## Structure
- Shared package `rv_m_pkg`:
  - `m_op_e` enum for the funct3 encodings above;
  - `mdu_state_e` enum {IDLE, CALC, DONE};
  - constant `MDU_ITERS` = 32.
- A single module with no sub-module. Multiply and divide share the counter, the latched operands and the 64-bit accumulator register; a separate datapath module would only add port plumbing.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3): `done` in cycle N+33, `result` 0xFFFFFFEB. MULH of the same operands gives 0xFFFFFFFF.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF gives 0xFFFFFFFE. MULHSU 0xFFFFFFFF (−1) × 0xFFFFFFFF gives 0xFFFFFFFF.
- DIV −7 / 2 gives 0xFFFFFFFD, REM −7 / 2 gives 0xFFFFFFFF, DIVU 100 / 7 gives 14, REMU 100 / 7 gives 2. Each takes 33 cycles.
- DIVU 5 / 0 gives 0xFFFFFFFF, REM 5 / 0 gives 5, DIV 0x80000000 / −1 gives 0x80000000, REM 0x80000000 / −1 gives 0. Each has `done` in cycle N+1.
- Busy robustness: pulse `start` again at cycle N+10 with different operands and toggle `opA` each cycle. The first result must be unaffected, with a single `done` at N+33.
- Reset mid-CALC: drop `rst` at cycle N+15. `busy`, `done` and `result` go to 0 immediately and asynchronously. A fresh MUL 3 × 4 afterwards returns 12.

Source files
------------

// File: rtl/rv_m_pkg.sv
// Shared RV32M definitions: funct3 op encodings, mul/div FSM states,
// iteration count and small op-class helpers.
package rv_m_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } m_op_e;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mdu_state_e;

  localparam int MDU_ITERS = 32;

  // funct3[2] separates the divide group from the multiply group
  function automatic logic op_is_div(m_op_e op);
    return op[2];
  endfunction

  // rs1 is treated as signed for MULH, MULHSU, DIV and REM
  function automatic logic op_signed_a(m_op_e op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  // rs2 is treated as signed for MULH, DIV and REM
  function automatic logic op_signed_b(m_op_e op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the core and the multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] opA;
  logic [XLEN-1:0] opB;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (output start, funct3, opA, opB, input busy, done, result);
  modport slave  (input start, funct3, opA, opB, output busy, done, result);
endinterface

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit. Multiply is radix-2 shift-add,
// divide is restoring division; both run 32 iterations sharing one
// counter, the latched operand magnitudes and a 64-bit accumulator.
module mul_div_unit
  import rv_m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_e        state, state_nxt;
  m_op_e             op, op_in;
  logic [5:0]        cnt;
  logic [2*XLEN-1:0] acc, acc_nxt, mul_nxt, div_nxt, prod;
  logic [XLEN-1:0]   a_reg, b_reg, result_r;
  logic              sign_a, sign_b, sign_a_in, sign_b_in;
  logic              accept, last, busy, done;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   special_res, calc_res, quo, rem;
  logic [XLEN:0]     mul_sum, trial;
  logic [XLEN-1:0]   sub_lo, new_rem;
  logic              q_bit;

  assign op_in     = m_op_e'(bus.funct3);
  assign accept    = (state == IDLE) && bus.start;
  assign last      = (cnt == 6'(MDU_ITERS - 1));
  assign sign_a_in = op_signed_a(op_in) & bus.opA[XLEN-1];
  assign sign_b_in = op_signed_b(op_in) & bus.opB[XLEN-1];

  // Special-case detection and result on the incoming request
  always_comb begin
    div_zero    = op_is_div(op_in) && (bus.opB == '0);
    div_ovf     = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
                  (bus.opA == MIN_NEG) && (bus.opB == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero)
      special_res = ((op_in == OP_DIV) || (op_in == OP_DIVU)) ? '1 : bus.opA;
    else if (div_ovf)
      special_res = (op_in == OP_DIV) ? MIN_NEG : '0;
  end

  // One iteration of shift-add multiply or restoring divide, plus final sign fix-up
  always_comb begin
    mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + (a_reg[0] ? {1'b0, b_reg} : '0);
    mul_nxt = {mul_sum, acc[XLEN-1:1]};
    trial   = {acc[2*XLEN-1:XLEN], a_reg[XLEN-1]};
    q_bit   = (trial >= {1'b0, b_reg});
    sub_lo  = trial[XLEN-1:0] - b_reg;
    new_rem = q_bit ? sub_lo : trial[XLEN-1:0];
    div_nxt = {new_rem, acc[XLEN-2:0], q_bit};
    acc_nxt = op_is_div(op) ? div_nxt : mul_nxt;
    prod    = (sign_a ^ sign_b) ? -acc_nxt : acc_nxt;
    quo     = (sign_a ^ sign_b) ? -acc_nxt[XLEN-1:0] : acc_nxt[XLEN-1:0];
    rem     = sign_a ? -acc_nxt[2*XLEN-1:XLEN] : acc_nxt[2*XLEN-1:XLEN];
    case (op)
      OP_MUL:            calc_res = prod[XLEN-1:0];
      OP_DIV, OP_DIVU:   calc_res = quo;
      OP_REM, OP_REMU:   calc_res = rem;
      default:           calc_res = prod[2*XLEN-1:XLEN];
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state and status outputs
  always_comb begin
    state_nxt = state;
    busy      = (state != IDLE);
    done      = (state == DONE);
    case (state)
      IDLE:    if (bus.start) state_nxt = special ? DONE : CALC;
      CALC:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op       <= OP_MUL;
      a_reg    <= '0;
      b_reg    <= '0;
      sign_a   <= 1'b0;
      sign_b   <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      result_r <= '0;
    end else if (accept) begin
      op     <= op_in;
      sign_a <= sign_a_in;
      sign_b <= sign_b_in;
      a_reg  <= sign_a_in ? -bus.opA : bus.opA;
      b_reg  <= sign_b_in ? -bus.opB : bus.opB;
      cnt    <= '0;
      acc    <= '0;
      if (special) result_r <= special_res;
    end else if (state == CALC) begin
      acc   <= acc_nxt;
      a_reg <= op_is_div(op) ? {a_reg[XLEN-2:0], 1'b0} : {1'b0, a_reg[XLEN-1:1]};
      cnt   <= cnt + 6'd1;
      if (last) result_r <= calc_res;
    end
  end

  assign bus.busy   = busy;
  assign bus.done   = done;
  assign bus.result = result_r;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: hand-computed vectors, latency,
// busy/done framing, start-while-busy robustness and async reset.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  // Issue one op and watch 36 cycles; optionally disturb inputs while busy
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input bit disturb);
    int first, ndone;
    logic busy1, idle_busy;
    logic [31:0] res;
    first = 0; ndone = 0; busy1 = 1'b0; idle_busy = 1'b1; res = '0;
    @(negedge clk);
    bus.funct3 = f;
    bus.opA    = a;
    bus.opB    = b;
    bus.start  = 1'b1;
    #1;
    chk({tag, "_busy_n"}, bus.busy, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 36; k++) begin
      @(negedge clk);
      if (k == 1) busy1 = bus.busy;
      if (bus.done) begin
        ndone++;
        if (first == 0) begin
          first = k;
          res   = bus.result;
        end
      end
      if ((first != 0) && (k == first + 1)) idle_busy = bus.busy;
      if (disturb) begin
        bus.opA    = ~bus.opA;
        bus.opB    = 32'd5;
        bus.funct3 = 3'b100;
        bus.start  = (k == 10);
      end
    end
    bus.start = 1'b0;
    chk({tag, "_lat"}, first, exp_lat);
    chk({tag, "_res"}, res, exp_res);
    chk({tag, "_ndone"}, ndone, 1);
    chk({tag, "_busy1"}, busy1, 1'b1);
    chk({tag, "_idle"}, idle_busy, 1'b0);
    chk({tag, "_hold"}, bus.result, exp_res);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst        = 1'b0;
    bus.start  = 1'b0;
    bus.funct3 = 3'b000;
    bus.opA    = '0;
    bus.opB    = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_done", bus.done, 1'b0);
    chk("rst_result", bus.result, 32'h0);
    rst = 1'b1;

    run_op("mul",    3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b0);
    run_op("mulh",   3'b001, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFE, 33, 1'b0);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF,  32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1'b0);
    run_op("mul_lo", 3'b000, 32'h12345678,  32'h00000010, 32'h23456780, 33, 1'b0);
    run_op("div",    3'b100, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFD, 33, 1'b0);
    run_op("rem",    3'b110, 32'hFFFFFFF9,  32'd2,        32'hFFFFFFFF, 33, 1'b0);
    run_op("divu",   3'b101, 32'd100,       32'd7,        32'd14,       33, 1'b0);
    run_op("remu",   3'b111, 32'd100,       32'd7,        32'd2,        33, 1'b0);
    run_op("div_nb", 3'b100, 32'd20,        32'hFFFFFFFD, 32'hFFFFFFFA, 33, 1'b0);
    run_op("rem_nb", 3'b110, 32'd20,        32'hFFFFFFFD, 32'd2,        33, 1'b0);
    run_op("divu_z", 3'b101, 32'd5,         32'd0,        32'hFFFFFFFF, 1,  1'b0);
    run_op("rem_z",  3'b110, 32'd5,         32'd0,        32'd5,        1,  1'b0);
    run_op("div_ov", 3'b100, 32'h80000000,  32'hFFFFFFFF, 32'h80000000, 1,  1'b0);
    run_op("rem_ov", 3'b110, 32'h80000000,  32'hFFFFFFFF, 32'h0,        1,  1'b0);
    run_op("robust", 3'b000, 32'd7,         32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1'b1);

    // Reset in the middle of a calculation
    @(negedge clk);
    bus.funct3 = 3'b000;
    bus.opA    = 32'h12345678;
    bus.opB    = 32'h9ABCDEF0;
    bus.start  = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    chk("mid_busy", bus.busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_done", bus.done, 1'b0);
    chk("arst_result", bus.result, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    run_op("post_rst", 3'b000, 32'd3, 32'd4, 32'd12, 33, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
